// File: rtl/debug_module.sv
// rtl/debug_module.sv - RISC-V debug module subset: DMI register file, halt/resume, GPR abstract access
//
// Sits behind the DTM. Every DMI request is answered one cycle later. Holds data0,
// dmcontrol, dmstatus, hartinfo, abstractcs and command, drives halt/resume levels
// to the core and runs "access register" commands on x0..x31 over a req/ack port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dmi_req_valid/addr/data/op   request strobe, 7-bit address, write data, op (01 rd, 10 wr)
//   dmi_rsp_valid/data       response strobe (one cycle after request) and read data
//   dbg_halt_req             haltreq & dmactive
//   dbg_resume_req           held until the core leaves debug mode
//   dbg_halted               core is in debug mode
//   ndmreset                 dmcontrol.ndmreset & dmactive
//   dbg_reg_req/wr/addr/wdata    GPR access request, held until ack; wdata is data0
//   dbg_reg_rdata/ack        GPR read value and one-cycle completion
module debug_module #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi_req_valid,
  input  logic [6:0]  dmi_req_addr,
  input  logic [31:0] dmi_req_data,
  input  logic [1:0]  dmi_req_op,
  output logic        dmi_rsp_valid,
  output logic [31:0] dmi_rsp_data,
  output logic        dbg_halt_req,
  output logic        dbg_resume_req,
  input  logic        dbg_halted,
  output logic        ndmreset,
  output logic        dbg_reg_req,
  output logic        dbg_reg_wr,
  output logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_wdata,
  input  logic [31:0] dbg_reg_rdata,
  input  logic        dbg_reg_ack
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [2:0] CMDERR_NONE    = 3'd0;
  localparam logic [2:0] CMDERR_BUSY    = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP  = 3'd2;
  localparam logic [2:0] CMDERR_HALT    = 3'd4;
  localparam logic [2:0] CMDERR_TIMEOUT = 3'd7;

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data0_q, data0_d;
  logic               dmactive_q, dmactive_d;
  logic               haltreq_q, haltreq_d;
  logic               ndmreset_q, ndmreset_d;
  logic               resume_req_q, resume_req_d;
  logic               resumeack_q, resumeack_d;
  logic [2:0]         cmderr_q, cmderr_d;
  logic               reg_wr_q, reg_wr_d;
  logic [4:0]         reg_addr_q, reg_addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic               is_rd, is_wr, busy, busy_hit;
  logic [31:0]        rdata;
  logic [7:0]         cmd_type;
  logic [2:0]         cmd_aarsize;
  logic               cmd_transfer, cmd_write, regno_ok;

  assign is_rd = dmi_req_valid && (dmi_req_op == 2'b01);
  assign is_wr = dmi_req_valid && (dmi_req_op == 2'b10);
  assign busy  = (state_q == ST_XFER);

  // Accesses that collide with an in-flight abstract command.
  assign busy_hit = (is_wr && (dmi_req_addr == ADDR_DATA0 || dmi_req_addr == ADDR_ABSTRACTCS ||
                               dmi_req_addr == ADDR_COMMAND)) ||
                    (is_rd && dmi_req_addr == ADDR_DATA0);

  assign cmd_type     = dmi_req_data[31:24];
  assign cmd_aarsize  = dmi_req_data[22:20];
  assign cmd_transfer = dmi_req_data[17];
  assign cmd_write    = dmi_req_data[16];
  // GPRs live at regno 0x1000..0x101F.
  assign regno_ok     = (dmi_req_data[15:5] == 11'h080);

  always_comb begin
    rdata = '0;
    case (dmi_req_addr)
      ADDR_DATA0:      rdata = data0_q;
      ADDR_DMCONTROL:  rdata = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
      ADDR_DMSTATUS:   rdata = {14'b0, resumeack_q, resumeack_q, 4'b0,
                                ~dbg_halted, ~dbg_halted, dbg_halted, dbg_halted,
                                1'b1, 3'b0, 4'd2};
      ADDR_HARTINFO:   rdata = '0;
      ADDR_ABSTRACTCS: rdata = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr_q, 4'b0, 4'd1};
      default:         rdata = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data0_d      = data0_q;
    dmactive_d   = dmactive_q;
    haltreq_d    = haltreq_q;
    ndmreset_d   = ndmreset_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    cmderr_d     = cmderr_q;
    reg_wr_d     = reg_wr_q;
    reg_addr_d   = reg_addr_q;
    rsp_valid_d  = dmi_req_valid;
    rsp_data_d   = is_rd ? rdata : '0;

    // In-flight GPR access: ack wins over a timeout landing on the same cycle.
    if (state_q == ST_XFER) begin
      if (dbg_reg_ack) begin
        state_d = ST_IDLE;
        if (!reg_wr_q) begin
          data0_d = dbg_reg_rdata;
        end
      end else if (cnt_q == CNT_LAST) begin
        state_d  = ST_IDLE;
        cmderr_d = CMDERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (resume_req_q && !dbg_halted) begin
      resume_req_d = 1'b0;
      resumeack_d  = 1'b1;
    end

    if (is_wr && dmi_req_addr == ADDR_DMCONTROL) begin
      dmactive_d = dmi_req_data[0];
      haltreq_d  = dmi_req_data[31];
      ndmreset_d = dmi_req_data[1];
      if (dmi_req_data[30] && !dmi_req_data[31] && dbg_halted) begin
        resumeack_d  = 1'b0;
        resume_req_d = 1'b1;
      end
    end

    if (dmactive_q) begin
      if (busy) begin
        // Timeout's cmderr is already in cmderr_d and is not overwritten here.
        if (busy_hit && cmderr_d == CMDERR_NONE) begin
          cmderr_d = CMDERR_BUSY;
        end
      end else if (is_wr) begin
        case (dmi_req_addr)
          ADDR_DATA0:      data0_d  = dmi_req_data;
          ADDR_ABSTRACTCS: cmderr_d = cmderr_q & ~dmi_req_data[10:8];
          ADDR_COMMAND: begin
            if (cmderr_q == CMDERR_NONE) begin
              if (cmd_type != 8'd0 || cmd_aarsize != 3'd2 || (cmd_transfer && !regno_ok)) begin
                cmderr_d = CMDERR_NOTSUP;
              end else if (!dbg_halted) begin
                cmderr_d = CMDERR_HALT;
              end else if (cmd_transfer) begin
                state_d    = ST_XFER;
                cnt_d      = '0;
                reg_wr_d   = cmd_write;
                reg_addr_d = dmi_req_data[4:0];
              end
            end
          end
          default: ;
        endcase
      end
    end

    // An inactive module keeps everything but dmactive at reset values.
    if (!dmactive_d) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      data0_d      = '0;
      haltreq_d    = 1'b0;
      ndmreset_d   = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
      cmderr_d     = CMDERR_NONE;
      reg_wr_d     = 1'b0;
      reg_addr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data0_q      <= '0;
      dmactive_q   <= 1'b0;
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
      cmderr_q     <= CMDERR_NONE;
      reg_wr_q     <= 1'b0;
      reg_addr_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data0_q      <= data0_d;
      dmactive_q   <= dmactive_d;
      haltreq_q    <= haltreq_d;
      ndmreset_q   <= ndmreset_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
      cmderr_q     <= cmderr_d;
      reg_wr_q     <= reg_wr_d;
      reg_addr_q   <= reg_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign dmi_rsp_valid  = rsp_valid_q;
  assign dmi_rsp_data   = rsp_data_q;
  assign dbg_halt_req   = haltreq_q & dmactive_q;
  assign dbg_resume_req = resume_req_q;
  assign ndmreset       = ndmreset_q & dmactive_q;
  assign dbg_reg_req    = (state_q == ST_XFER);
  assign dbg_reg_wr     = reg_wr_q;
  assign dbg_reg_addr   = reg_addr_q;
  assign dbg_reg_wdata  = data0_q;

endmodule

// File: tb/tb_debug_module.sv
// tb/tb_debug_module.sv - randomized bench for debug_module against a register-level reference model
module tb_debug_module;
  logic        clk = 1'b0;
  logic        rst;
  logic        dmi_req_valid;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid;
  logic [31:0] dmi_rsp_data;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_halted;
  logic        ndmreset;
  logic        dbg_reg_req;
  logic        dbg_reg_wr;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_wdata;
  logic [31:0] dbg_reg_rdata;
  logic        dbg_reg_ack;

  debug_module #(.ACK_TIMEOUT(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_rsp_valid  (dmi_rsp_valid),
    .dmi_rsp_data   (dmi_rsp_data),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_halted     (dbg_halted),
    .ndmreset       (ndmreset),
    .dbg_reg_req    (dbg_reg_req),
    .dbg_reg_wr     (dbg_reg_wr),
    .dbg_reg_addr   (dbg_reg_addr),
    .dbg_reg_wdata  (dbg_reg_wdata),
    .dbg_reg_rdata  (dbg_reg_rdata),
    .dbg_reg_ack    (dbg_reg_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Core register file and debug-module architectural state.
  logic [31:0] gpr [32];
  logic [31:0] m_data0;
  logic        m_dmactive, m_haltreq, m_ndmreset, m_resumeack, m_resuming, m_busy;
  logic [2:0]  m_cmderr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      7'h04: v = m_data0;
      7'h10: v = {m_haltreq, 29'b0, m_ndmreset, m_dmactive};
      7'h11: begin
        v = 32'h0000_0082;
        v = v | (dbg_halted ? 32'h0000_0300 : 32'h0000_0C00);
        if (m_resumeack) v = v | 32'h0003_0000;
      end
      7'h16: begin
        v = 32'h1 | (32'(m_cmderr) << 8);
        if (m_busy) v = v | 32'h0000_1000;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic m_reset_state();
    m_data0 = 0; m_haltreq = 0; m_ndmreset = 0; m_resumeack = 0;
    m_resuming = 0; m_cmderr = 0; m_busy = 0;
  endtask

  // Apply a write to the model (module assumed not busy); xfer = GPR access expected.
  task automatic m_write(input logic [6:0] a, input logic [31:0] d, output bit xfer);
    xfer = 0;
    if (a == 7'h10) begin
      m_dmactive = d[0];
      if (!d[0]) m_reset_state();
      else begin
        m_haltreq  = d[31];
        m_ndmreset = d[1];
        if (d[30] && !d[31] && dbg_halted) begin
          m_resumeack = 0;
          m_resuming  = 1;
        end
      end
    end else if (m_dmactive) begin
      if (a == 7'h04) m_data0 = d;
      else if (a == 7'h16) m_cmderr = m_cmderr & ~d[10:8];
      else if (a == 7'h17 && m_cmderr == 0) begin
        if (d[31:24] != 0 || d[22:20] != 3'd2 ||
            (d[17] && (d[15:0] < 16'h1000 || d[15:0] > 16'h101F))) m_cmderr = 2;
        else if (!dbg_halted) m_cmderr = 4;
        else if (d[17]) xfer = 1;
      end
    end
  endtask

  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    chk("rsp_idle", 32'(dmi_rsp_valid), 32'h0);
    dmi_req_valid = 1'b1;
    dmi_req_op    = op;
    dmi_req_addr  = a;
    dmi_req_data  = wd;
    @(negedge clk);
    dmi_req_valid = 1'b0;
    dmi_req_op    = 2'b00;
    chk("rsp_valid", 32'(dmi_rsp_valid), 32'h1);
    rd = dmi_rsp_data;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, output bit xfer);
    logic [31:0] rd;
    dmi(2'b10, a, d, rd);
    chk("wr_rsp_data", rd, 32'h0);
    m_write(a, d, xfer);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    logic [31:0] rd;
    dmi(2'b01, a, 32'h0, rd);
    chk(tag, rd, m_read(a));
  endtask

  // Act as the core for one abstract GPR access.
  task automatic core_serve(input logic [31:0] cmd);
    int n;
    logic [4:0] r;
    bit w;
    n = 0;
    r = cmd[4:0];
    w = cmd[16];
    while (!dbg_reg_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("reg_req_up", 32'(dbg_reg_req), 32'h1);
    chk("reg_wr", 32'(dbg_reg_wr), 32'(w));
    chk("reg_addr", 32'(dbg_reg_addr), 32'(r));
    if (w) chk("reg_wdata", dbg_reg_wdata, m_data0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    dbg_reg_ack   = 1'b1;
    dbg_reg_rdata = w ? $urandom : gpr[r];
    if (w) gpr[r] = m_data0;
    else   m_data0 = gpr[r];
    @(negedge clk);
    dbg_reg_ack = 1'b0;
    chk("reg_req_down", 32'(dbg_reg_req), 32'h0);
  endtask

  task automatic chk_levels();
    chk("halt_req", 32'(dbg_halt_req), 32'(m_haltreq & m_dmactive));
    chk("ndmreset", 32'(ndmreset), 32'(m_ndmreset & m_dmactive));
    chk("resume_req", 32'(dbg_resume_req), 32'(m_resuming));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          xfer;
    logic [31:0] rd;
    logic [31:0] cmd;
    int          c0, n;

    rst = 1'b1;
    dmi_req_valid = 0; dmi_req_addr = 0; dmi_req_data = 0; dmi_req_op = 0;
    dbg_halted = 0; dbg_reg_rdata = 0; dbg_reg_ack = 0;
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    gpr[5] = 32'hDEAD_BEEF;
    m_dmactive = 0;
    m_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_rsp_valid", 32'(dmi_rsp_valid), 32'h0);
    chk("rst_reg_req", 32'(dbg_reg_req), 32'h0);
    chk("rst_reg_wr", 32'(dbg_reg_wr), 32'h0);
    chk("rst_reg_addr", 32'(dbg_reg_addr), 32'h0);
    chk("rst_reg_wdata", dbg_reg_wdata, 32'h0);
    chk_levels();
    rd_chk("rst_dmstatus", 7'h11);
    rd_chk("rst_abstractcs", 7'h16);

    // Halt
    wr(7'h10, 32'h8000_0001, xfer);
    chk_levels();
    dbg_halted = 1'b1;
    rd_chk("halted_dmstatus", 7'h11);
    rd_chk("dmcontrol", 7'h10);

    // GPR read x5
    cmd = 32'h0022_1005;
    wr(7'h17, cmd, xfer);
    chk("x5_xfer_expected", 32'(dbg_reg_req), 32'(xfer));
    if (xfer) core_serve(cmd);
    rd_chk("data0_x5", 7'h04);

    // Command while running
    dbg_halted = 1'b0;
    wr(7'h17, 32'h0023_1001, xfer);
    chk("running_no_req", 32'(dbg_reg_req), 32'h0);
    rd_chk("cmderr4", 7'h16);
    wr(7'h16, 32'h0000_0700, xfer);
    rd_chk("cmderr_clr", 7'h16);

    // Timeout
    dbg_halted = 1'b1;
    wr(7'h17, 32'h0022_1003, xfer);
    c0 = cyc;
    n = 0;
    while (dbg_reg_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_req_low", 32'(dbg_reg_req), 32'h0);
    chk("busy_cycles", 32'(cyc - c0), 32'd255);
    m_cmderr = 3'd7;
    rd_chk("cmderr7", 7'h16);
    wr(7'h16, 32'h0000_0700, xfer);

    // Command during busy
    cmd = 32'h0023_1009;
    wr(7'h00 | 7'h04, $urandom, xfer);
    wr(7'h17, cmd, xfer);
    m_busy = 1'b1;
    dmi(2'b10, 7'h17, 32'h0022_1002, rd);
    m_cmderr = 3'd1;
    rd_chk("busy_cmd_cmderr1", 7'h16);
    m_busy = 1'b0;
    core_serve(cmd);
    rd_chk("after_busy_abscs", 7'h16);
    wr(7'h16, 32'h0000_0700, xfer);
    rd_chk("clr_after_busy", 7'h16);

    // data0 access during busy
    cmd = 32'h0022_1007;
    wr(7'h17, cmd, xfer);
    m_busy = 1'b1;
    rd_chk("busy_data0_old", 7'h04);
    m_cmderr = 3'd1;
    dmi(2'b10, 7'h04, 32'h1234_5678, rd);
    rd_chk("busy_data0_cmderr1", 7'h16);
    m_busy = 1'b0;
    core_serve(cmd);
    rd_chk("data0_x7", 7'h04);
    wr(7'h16, 32'h0000_0700, xfer);

    // Resume
    wr(7'h10, 32'h4000_0001, xfer);
    chk_levels();
    rd_chk("resume_dmstatus", 7'h11);
    @(negedge clk);
    dbg_halted = 1'b0;
    @(negedge clk);
    m_resuming  = 1'b0;
    m_resumeack = 1'b1;
    chk_levels();
    rd_chk("resumeack_dmstatus", 7'h11);
    wr(7'h10, 32'h4000_0001, xfer);
    chk_levels();

    // Deactivate
    wr(7'h10, 32'h8000_0003, xfer);
    chk_levels();
    wr(7'h10, 32'h0000_0000, xfer);
    chk_levels();
    rd_chk("inactive_data0", 7'h04);
    wr(7'h04, 32'hCAFE_F00D, xfer);
    rd_chk("inactive_data0_wr", 7'h04);
    rd_chk("inactive_dmstatus", 7'h11);
    wr(7'h10, 32'h0000_0001, xfer);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int k;
      logic [31:0] d;
      logic [6:0]  a;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) dbg_halted = ~dbg_halted;
      case (k)
        0: wr(7'h04, $urandom, xfer);
        1: rd_chk("rnd_data0", 7'h04);
        2, 3: begin
          d = {8'h00, 1'b0, 3'd2, 2'b00, 1'b1, (k == 2), 11'h080, 5'($urandom_range(0, 31))};
          wr(7'h17, d, xfer);
          chk("rnd_req_expect", 32'(dbg_reg_req), 32'(xfer));
          if (xfer && dbg_reg_req) core_serve(d);
        end
        4: begin
          d = $urandom;
          if ($urandom_range(0, 1) == 1) d[31:24] = 8'h00;
          if ($urandom_range(0, 1) == 1) d[22:20] = 3'd2;
          wr(7'h17, d, xfer);
          chk("rnd_raw_req_expect", 32'(dbg_reg_req), 32'(xfer));
          if (xfer && dbg_reg_req) core_serve(d);
        end
        5: begin
          d = 32'h0000_0001;
          d[31] = 1'($urandom_range(0, 1));
          d[1]  = 1'($urandom_range(0, 1));
          wr(7'h10, d, xfer);
        end
        6: rd_chk("rnd_dmstatus", 7'h11);
        7: rd_chk("rnd_abstractcs", 7'h16);
        8: wr(7'h16, $urandom, xfer);
        default: begin
          a = 7'($urandom);
          while (a == 7'h04 || a == 7'h10 || a == 7'h11 || a == 7'h16 || a == 7'h17)
            a = 7'($urandom);
          dmi(2'($urandom), a, $urandom, rd);
          chk("rnd_unmapped", rd, 32'h0);
        end
      endcase
      chk_levels();
    end
    rd_chk("final_data0", 7'h04);
    rd_chk("final_abstractcs", 7'h16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
